// File: rtl/usr_pkg.sv
// Shared types and helpers for the universal shift register (univ_shift_reg).
package usr_pkg;

   typedef enum logic [2:0] {
      OP_HOLD = 3'b000,
      OP_LOAD = 3'b001,
      OP_SLL  = 3'b010,
      OP_SRL  = 3'b011,
      OP_ROL  = 3'b100,
      OP_ROR  = 3'b101,
      OP_SRA  = 3'b110,
      OP_CLR  = 3'b111
   } usr_op_e;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } usr_state_e;

   // Only the five shift/rotate codes may drive a burst.
   function automatic logic is_shift_op(input logic [2:0] op);
      return (op >= 3'b010) && (op <= 3'b110);
   endfunction

endpackage

// File: rtl/usr_shift_core.sv
// Combinational next-value mux for univ_shift_reg: load, shifts, rotates, clear.
module usr_shift_core
   import usr_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] q,
   input  usr_op_e          op,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q_next
);

   always_comb begin
      q_next = q;
      unique case (op)
         OP_HOLD: q_next = q;
         OP_LOAD: q_next = d;
         OP_SLL:  q_next = {q[WIDTH-2:0], sin_r};
         OP_SRL:  q_next = {sin_l, q[WIDTH-1:1]};
         OP_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
         OP_ROR:  q_next = {q[0], q[WIDTH-1:1]};
         OP_SRA:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
         OP_CLR:  q_next = '0;
         default: q_next = q;
      endcase
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step ops and an autonomous N-shift burst engine.
// Optional registered parity output enabled by defining USR_PARITY_EN.
module univ_shift_reg
   import usr_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               CNT_W     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin_l,
   input  logic             sin_r,
   input  logic             start,
   input  logic [CNT_W-1:0] burst_len,
   input  logic [2:0]       burst_mode,
   output logic [WIDTH-1:0] q,
   output logic             sout_l,
   output logic             sout_r,
   output logic             busy,
   output logic             done
`ifdef USR_PARITY_EN
   ,
   output logic             parity
`endif
);

   usr_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   usr_op_e          bop_q, bop_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             done_q, done_d;
   usr_op_e          op_sel;

   usr_shift_core #(.WIDTH(WIDTH)) u_core (
      .q      (q_q),
      .op     (op_sel),
      .sin_l  (sin_l),
      .sin_r  (sin_r),
      .d      (d),
      .q_next (q_d)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bop_d   = bop_q;
      done_d  = 1'b0;
      op_sel  = OP_HOLD;
      unique case (state_q)
         IDLE: begin
            // start outranks en; the start edge itself never shifts
            if (start) begin
               if (burst_len != '0) begin
                  state_d = BURST;
                  cnt_d   = burst_len;
                  bop_d   = is_shift_op(burst_mode) ? usr_op_e'(burst_mode) : OP_HOLD;
               end else begin
                  done_d = 1'b1;
               end
            end else if (en) begin
               op_sel = usr_op_e'(mode);
            end
         end
         BURST: begin
            op_sel = bop_q;
            cnt_d  = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bop_q   <= OP_HOLD;
         q_q     <= RESET_VAL;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bop_q   <= bop_d;
         q_q     <= q_d;
         done_q  <= done_d;
      end
   end

`ifdef USR_PARITY_EN
   logic parity_q;

   always_ff @(posedge clk) begin
      if (reset) parity_q <= ^RESET_VAL;
      else       parity_q <= ^q_d;
   end

   assign parity = parity_q;
`endif

   assign q      = q_q;
   assign sout_l = q_q[WIDTH-1];
   assign sout_r = q_q[0];
   assign busy   = (state_q == BURST);
   assign done   = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg (WIDTH=8, RESET_VAL=8'hA5, CNT_W=4).
module tb_univ_shift_reg;

   logic       clk = 1'b0;
   logic       reset, en, sin_l, sin_r, start;
   logic [2:0] mode, burst_mode;
   logic [7:0] d;
   logic [3:0] burst_len;
   logic [7:0] q;
   logic       sout_l, sout_r, busy, done;
`ifdef USR_PARITY_EN
   logic       parity;
`endif

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [7:0]  cap;

   always #5 clk = ~clk;

   univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .CNT_W(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .mode       (mode),
      .d          (d),
      .sin_l      (sin_l),
      .sin_r      (sin_r),
      .start      (start),
      .burst_len  (burst_len),
      .burst_mode (burst_mode),
      .q          (q),
      .sout_l     (sout_l),
      .sout_r     (sout_r),
      .busy       (busy),
      .done       (done)
`ifdef USR_PARITY_EN
      ,
      .parity     (parity)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
`ifdef USR_PARITY_EN
      chk("parity", 32'(parity), 32'(^q));
`endif
   endtask

   task automatic op(input logic [2:0] m, input logic [7:0] dv, input logic [7:0] exp, input string tag);
      en = 1'b1; mode = m; d = dv;
      tick();
      chk(tag, 32'(q), 32'(exp));
      en = 1'b0;
   endtask

   initial begin
      reset = 1'b1; en = 1'b0; mode = 3'b000; d = '0; sin_l = 1'b0; sin_r = 1'b0;
      start = 1'b0; burst_len = '0; burst_mode = 3'b000;

      // 1. reset
      tick(); tick();
      chk("rst_q", 32'(q), 32'h A5);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      reset = 1'b0;
      op(3'b000, 8'h00, 8'hA5, "hold");

      // 2. single ops
      op(3'b001, 8'h96, 8'h96, "load");
      op(3'b110, 8'h00, 8'hCB, "sra");
      op(3'b101, 8'h00, 8'hE5, "ror");
      sin_r = 1'b1;
      op(3'b010, 8'h00, 8'hCB, "sll");
      sin_r = 1'b0;
      op(3'b100, 8'h00, 8'h97, "rol");
      op(3'b111, 8'h00, 8'h00, "clr");
      sin_l = 1'b1;
      op(3'b011, 8'h00, 8'h80, "srl");
      sin_l = 1'b0;
      chk("sout_l", 32'(sout_l), 32'd1);
      chk("sout_r", 32'(sout_r), 32'd0);
      en = 1'b0;
      tick();
      chk("en0_hold", 32'(q), 32'h80);

      // 3. burst of 3 ROL with load requested throughout
      op(3'b001, 8'h81, 8'h81, "load81");
      en = 1'b1; mode = 3'b001; d = 8'hFF;
      start = 1'b1; burst_len = 4'd3; burst_mode = 3'b100;
      tick();
      start = 1'b0;
      chk("b_start_q", 32'(q), 32'h81);
      chk("b_start_busy", 32'(busy), 32'd1);
      tick();
      chk("b1_q", 32'(q), 32'h03);
      chk("b1_busy", 32'(busy), 32'd1);
      chk("b1_done", 32'(done), 32'd0);
      tick();
      chk("b2_q", 32'(q), 32'h06);
      chk("b2_done", 32'(done), 32'd0);
      tick();
      chk("b3_q", 32'(q), 32'h0C);
      chk("b3_done", 32'(done), 32'd1);
      chk("b3_busy", 32'(busy), 32'd0);
      en = 1'b0;
      tick();
      chk("b_after_done", 32'(done), 32'd0);
      chk("b_after_q", 32'(q), 32'h0C);

      // 4a. zero-length burst
      start = 1'b1; burst_len = 4'd0; burst_mode = 3'b010;
      tick();
      start = 1'b0;
      chk("z_done", 32'(done), 32'd1);
      chk("z_busy", 32'(busy), 32'd0);
      chk("z_q", 32'(q), 32'h0C);
      tick();
      chk("z_done_clr", 32'(done), 32'd0);

      // 4b. start and en together: burst wins
      start = 1'b1; burst_len = 4'd1; burst_mode = 3'b011; en = 1'b1; mode = 3'b111;
      tick();
      start = 1'b0; en = 1'b0;
      chk("se_q", 32'(q), 32'h0C);
      chk("se_busy", 32'(busy), 32'd1);
      tick();
      chk("se_q_fin", 32'(q), 32'h06);
      chk("se_done", 32'(done), 32'd1);

      // 4c. illegal burst op behaves as hold but still counts
      start = 1'b1; burst_len = 4'd2; burst_mode = 3'b111;
      tick();
      start = 1'b0;
      tick();
      chk("ill_q1", 32'(q), 32'h06);
      chk("ill_done1", 32'(done), 32'd0);
      tick();
      chk("ill_q2", 32'(q), 32'h06);
      chk("ill_done2", 32'(done), 32'd1);

      // 5. reset mid-burst
      op(3'b001, 8'hF0, 8'hF0, "loadF0");
      start = 1'b1; burst_len = 4'd5; burst_mode = 3'b011; sin_l = 1'b0;
      tick();
      start = 1'b0;
      tick();
      chk("mr_q1", 32'(q), 32'h78);
      tick();
      chk("mr_q2", 32'(q), 32'h3C);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mr_rst_q", 32'(q), 32'hA5);
      chk("mr_rst_busy", 32'(busy), 32'd0);
      chk("mr_rst_done", 32'(done), 32'd0);
      tick();
      chk("mr_idle_busy", 32'(busy), 32'd0);
      chk("mr_idle_done", 32'(done), 32'd0);
      chk("mr_idle_q", 32'(q), 32'hA5);

      // 6. serialiser loop: sout_l fed back into sin_r
      op(3'b001, 8'h5A, 8'h5A, "load5A");
      start = 1'b1; burst_len = 4'd8; burst_mode = 3'b010;
      tick();
      start = 1'b0;
      cap = '0;
      for (int i = 0; i < 8; i++) begin
         cap   = {cap[6:0], sout_l};
         sin_r = sout_l;
         tick();
         chk("ser_done", 32'(done), (i == 7) ? 32'd1 : 32'd0);
      end
      sin_r = 1'b0;
      chk("ser_q", 32'(q), 32'h5A);
      chk("ser_bits", 32'(cap), 32'h5A);
      tick();
      chk("ser_busy_after", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised successor to the single-bit D flip-flop: a WIDTH-bit register with parallel load, logical, arithmetic and rotate shifts, and a burst engine that performs N consecutive shifts autonomously. It is used as the general-purpose storage and serialiser primitive in the library, for example for SPI/UART datapaths and delay lines. All state sits in one clock domain.

Parameters:
WIDTH, 8, register width in bits; must be at least 2.
RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
CNT_W, 4, width of the burst-length input; the maximum burst is 2^CNT_W-1 shifts.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
en  input  1  single-step enable; ignored while busy.
mode  input  3  operation select, see Behaviour.
d  input  WIDTH  parallel load data.
sin_l  input  1  serial input inserted at the MSB on right shifts.
sin_r  input  1  serial input inserted at the LSB on left shifts.
start  input  1  burst request, sampled only in IDLE.
burst_len  input  CNT_W  number of shifts in the burst; 0 means no shift.
burst_mode  input  3  shift op for the burst; only codes 010-110 are legal.
q  output  WIDTH  register contents.
sout_l  output  1  equal to q[WIDTH-1].
sout_r  output  1  equal to q[0].
busy  output  1  high while in BURST.
done  output  1  one-cycle pulse on the last burst shift.

Behaviour:
- Reset, sampled on a clk edge: q=RESET_VAL, FSM=IDLE, busy=0, done=0, burst counter=0, latched burst op=000. Reset overrides everything, including a burst in progress.
- mode codes. Each takes effect at the next edge, so latency is 1 cycle.
  - 000 hold.
  - 001 load d.
  - 010 SLL: {q[W-2:0],sin_r}.
  - 011 SRL: {sin_l,q[W-1:1]}.
  - 100 ROL: {q[W-2:0],q[W-1]}.
  - 101 ROR: {q[0],q[W-1:1]}.
  - 110 SRA: {q[W-1],q[W-1:1]}.
  - 111 clear: all zeros, not RESET_VAL.
- IDLE:
  - With en=1, apply mode. With en=0, hold.
  - start=1 and burst_len!=0: latch burst_mode and burst_len, go to BURST, busy=1 from the next cycle. No shift happens on the start edge.
  - start has priority over en in the same cycle.
  - start=1 with burst_len=0: stay IDLE, no shift, and done pulses for 1 cycle.
  - start=1 with an illegal burst_mode (000, 001, 111): treated as hold for the whole burst. Counting still runs and done still pulses.
- BURST:
  - Each cycle applies the latched op and decrements the counter.
  - On the edge where the counter goes 1->0, the final shift is applied, done=1 for that cycle, and the FSM returns to IDLE. busy falls on the same edge that done rises.
  - en, mode, d and start are ignored throughout.
  - sin_l and sin_r are sampled live each cycle, not latched.
- Burst timing: a burst of N shifts takes N cycles after the start edge. q is final in the cycle where done=1.
- Back-to-back: start is accepted again in the first IDLE cycle after done.
- sout_l and sout_r are combinational from q, with no added latency.

Optional Feature:
USR_PARITY_EN
- Defined: adds output parity (1 bit), a registered XOR-reduction of the next value of q. It updates on the same edge as q, so parity==^q always holds, and resets to ^RESET_VAL.
- Undefined: the parity port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package usr_pkg holds:
  - typedef usr_op_e, a 3-bit enum covering OP_HOLD, OP_LOAD, OP_SLL, OP_SRL, OP_ROL, OP_ROR, OP_SRA and OP_CLR;
  - typedef usr_state_e covering IDLE and BURST;
  - the function is_shift_op().
- Sub-module usr_shift_core: a purely combinational next-value mux taking q, op, sin_l and sin_r and producing q_next. The top level instantiates it once and feeds it either mode or the latched burst op.

Test Plan:
1. Reset: WIDTH=8, RESET_VAL=8'hA5; assert reset for 2 cycles, then en=1, mode=000 -> q=8'hA5, busy=0, done=0.
2. Single ops: load d=8'h96 -> q=8'h96. SRA -> 8'hCB. ROR -> 8'hE5. SLL with sin_r=1 -> 8'hCB. ROL -> 8'h97. Clear -> 8'h00.
3. Burst:
   - Load 8'h81, then start with burst_len=3 and burst_mode=ROL -> busy=1 for 3 cycles; q goes 8'h03, 8'h06, 8'h0C; done=1 with q=8'h0C; busy=0 after.
   - en/mode=001 held during the burst -> no effect.
4. Edge cases:
   - burst_len=0 -> done pulses with q unchanged.
   - start and en asserted together -> burst wins and q is not changed on that edge.
5. Reset mid-burst: start with burst_len=5 and SRL, then reset after 2 shifts -> q=RESET_VAL, IDLE, busy=0, and no done pulse.
6. Serialiser loop: load 8'h5A, burst of 8 SLL with sout_l fed back to sin_r -> q=8'h5A at done, and the captured sout_l sequence is 0,1,0,1,1,0,1,0.
   - With USR_PARITY_EN defined, parity equals ^q on every cycle of tests 2-6.
